column_painter: RTL and testbench
=================================

Name: column_painter

Overview:
- Downstream of the raycaster: double-buffered store of per-column wall slices (is_vert, Q16.16 height) that drives per-pixel RGB for the scanout timing.
- A sequential ray engine writes columns into the back bank through a valid/ready handshake.
- The screen timing reads the front bank.
- Banks swap only at frame start, and only after a complete frame has been written, so no tearing is visible.

Parameters:
- H_RES, 640, columns per frame and depth of each bank.
- V_RES, 480, visible lines; the horizon is at V_RES/2.
- HALF_W, 9, width of the stored half-height; must hold V_RES/2.

Ports:
- clk_in  in  1  pixel clock.
- rst_in  in  1  asynchronous, active-low reset.
- frame_in  in  1  one-cycle pulse at the start of vertical blanking (sy==V_RES, sx==0).
- wr_valid_in  in  1  column write request.
- wr_ready_out  out  1  writer can accept a column.
- wr_col_in  in  10  column index, 0..H_RES-1.
- wr_is_vert_in  in  1  wall hit was a vertical wall.
- wr_height_in  in  32  signed Q16.16 projected wall height.
- wr_last_in  in  1  marks the final column of the frame.
- sx_in, sy_in  in  10 each  screen position.
- de_in  in  1  data enable.
- sx_out, sy_out  out  10 each  position delayed 2 cycles.
- de_out  out  1  de delayed 2 cycles.
- r_out, g_out, b_out  out  8 each  pixel colour.
- swap_out  out  1  one-cycle pulse when the banks swap.
- front_valid_out  out  1  front bank holds a complete frame.
- col_err_out  out  1  sticky; set by an out-of-range column write.

Behaviour:
- Reset (async assert, sync release):
  - state=FILL, front=bank0 (back=bank1).
  - front_valid_out=0, swap_out=0, col_err_out=0, wr_ready_out=0 during reset and 1 after release.
  - All pixel and position outputs = 0.
  - Bank contents are not reset.
- Write transfer: occurs on a clock edge where wr_valid_in && wr_ready_out.
  - Stored entry = {is_vert, half}.
  - half = wr_height_in >>> 17 (arithmetic), saturated: negative gives 0; greater than V_RES/2 gives V_RES/2.
  - A wr_col_in >= H_RES write is accepted but not stored, and sets col_err_out; col_err_out clears only on reset.
  - wr_valid_in while wr_ready_out is low: no effect; the source holds the request.
- Writer FSM:
  - FILL: wr_ready_out=1. An accepted transfer with wr_last_in=1 moves to DONE on the next cycle. A column is not required to be written; unwritten entries keep stale data.
  - DONE: wr_ready_out=0. On frame_in: swap front/back, pulse swap_out for that single cycle, set front_valid_out=1, return to FILL.
  - frame_in while in FILL: no swap; the front bank repeats its old frame.
  - frame_in on the same edge as the wr_last_in transfer: no swap on that edge; the swap waits for the next frame_in.
- Read pipeline, fixed latency 2:
  - Cycle 0: register sx/sy/de and the front-bank select, and read the front bank at sx_in. Only indices < H_RES are read; for other indices de is low and data is don't-care.
  - Cycle 1: d = signed(sy) - V_RES/2. draw = front_valid && (-half < d) && (d < half), all strict.
  - Cycle 2: outputs registered.
  - Colour when de=0: 00,00,00.
  - Colour when draw and is_vert: ff,00,ff.
  - Colour when draw and not is_vert: cc,00,00.
  - Otherwise (including front_valid=0): 11,33,77.
- A swap changes the read bank only for pixels sampled after the swap edge; pixels already in the pipeline keep their bank.
- half=0 never draws.
- Read and write ports are independent (different banks), with no stalls on the read side.

Test Plan:
- Reset, then scan a full frame with no writes -> front_valid_out=0, all visible pixels 11,33,77, blanking 00,00,00, swap_out never pulses.
- Write 640 columns, height 0x00640000 (100.0 → half=50), is_vert=1, last on col 639, then frame_in -> swap_out pulses once. Next frame: rows 191..289 = ff,00,ff; rows 190 and 290 = 11,33,77. Outputs lag inputs by exactly 2 cycles.
- Saturation cases:
  - Height 0x7FFF0000 → column fully painted, rows 1..479 (row 0, d=-240, not drawn).
  - Height 0xFFF00000 (negative) → background only.
  - is_vert=0 → cc,00,00.
- Incomplete frame: write cols 0..319 without wr_last_in, pulse frame_in -> no swap, old frame repeats, wr_ready_out stays 1. Complete the frame, then frame_in -> swap.
- In DONE, hold wr_valid_in high -> wr_ready_out=0, no bank change.
- Same-edge last-write and frame_in -> no swap until the following frame_in.
- Write col 700 -> col_err_out=1 and sticky, no entry modified. Assert rst_in low mid-frame -> all outputs 0 immediately (asynchronous), state FILL, front_valid_out=0.

Source files
------------

// File: rtl/column_painter.sv
// Double-buffered per-column wall-slice store feeding per-pixel RGB. A ray engine fills the
// back bank. The scanout reads the front bank. The banks swap at frame start once a frame is complete.
module column_painter #(
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned HALF_W = 9
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_in,
  input  logic        wr_valid_in,
  output logic        wr_ready_out,
  input  logic [9:0]  wr_col_in,
  input  logic        wr_is_vert_in,
  input  logic [31:0] wr_height_in,
  input  logic        wr_last_in,
  input  logic [9:0]  sx_in,
  input  logic [9:0]  sy_in,
  input  logic        de_in,
  output logic [9:0]  sx_out,
  output logic [9:0]  sy_out,
  output logic        de_out,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        swap_out,
  output logic        front_valid_out,
  output logic        col_err_out
);

  localparam logic [9:0]         HResC    = 10'(H_RES);
  localparam logic signed [31:0] HalfMaxS = 32'(V_RES / 2);

  typedef enum logic {StFill, StDone} state_e;

  state_e state_q, state_d;
  logic   front_q, front_valid_q, swap_q, swap_d, err_q, ready_q;
  logic   accept, col_ok;

  // Entry layout: {is_vert, half}
  logic [HALF_W:0] bank0 [H_RES];
  logic [HALF_W:0] bank1 [H_RES];

  logic signed [31:0] shifted;
  logic [HALF_W-1:0]  half_w;
  logic [HALF_W:0]    wr_entry;

  logic [9:0]      rd_idx;
  logic [HALF_W:0] rd_q;
  logic [9:0]      sx_q1, sy_q1;
  logic            de_q1, fv_q1;

  int          d, half;
  logic        draw;
  logic [23:0] rgb_d;
  logic [23:0] rgb_q;
  logic [9:0]  sx_q2, sy_q2;
  logic        de_q2;

  assign accept   = wr_valid_in && wr_ready_out;
  assign col_ok   = wr_col_in < HResC;
  assign shifted  = $signed(wr_height_in) >>> 17;
  assign wr_entry = {wr_is_vert_in, half_w};

  always_comb begin
    half_w = shifted[HALF_W-1:0];
    if (shifted < 0) begin
      half_w = '0;
    end else if (shifted > HalfMaxS) begin
      half_w = HalfMaxS[HALF_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    swap_d  = 1'b0;
    unique case (state_q)
      StFill: if (accept && wr_last_in) state_d = StDone;
      StDone: begin
        if (frame_in) begin
          state_d = StFill;
          swap_d  = 1'b1;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Back bank is the one not being displayed.
  always_ff @(posedge clk_in) begin
    if (accept && col_ok) begin
      if (front_q) bank0[wr_col_in] <= wr_entry;
      else         bank1[wr_col_in] <= wr_entry;
    end
  end

  assign rd_idx = (sx_in < HResC) ? sx_in : '0;

  always_ff @(posedge clk_in) begin
    rd_q <= front_q ? bank1[rd_idx] : bank0[rd_idx];
  end

  always_comb begin
    d     = int'(sy_q1) - int'(V_RES / 2);
    half  = int'(rd_q[HALF_W-1:0]);
    draw  = fv_q1 && (-half < d) && (d < half);
    rgb_d = 24'h000000;
    if (de_q1) begin
      if (draw) rgb_d = rd_q[HALF_W] ? 24'hff00ff : 24'hcc0000;
      else      rgb_d = 24'h113377;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= StFill;
      front_q       <= 1'b0;
      front_valid_q <= 1'b0;
      swap_q        <= 1'b0;
      err_q         <= 1'b0;
      ready_q       <= 1'b0;
      sx_q1         <= '0;
      sy_q1         <= '0;
      de_q1         <= 1'b0;
      fv_q1         <= 1'b0;
      sx_q2         <= '0;
      sy_q2         <= '0;
      de_q2         <= 1'b0;
      rgb_q         <= '0;
    end else begin
      state_q       <= state_d;
      front_q       <= front_q ^ swap_d;
      front_valid_q <= front_valid_q | swap_d;
      swap_q        <= swap_d;
      err_q         <= err_q | (accept && !col_ok);
      ready_q       <= (state_d == StFill);
      // Bank select and valid are captured with the pixel so a swap never splits a pixel.
      sx_q1         <= sx_in;
      sy_q1         <= sy_in;
      de_q1         <= de_in;
      fv_q1         <= front_valid_q;
      sx_q2         <= sx_q1;
      sy_q2         <= sy_q1;
      de_q2         <= de_q1;
      rgb_q         <= rgb_d;
    end
  end

  assign wr_ready_out    = ready_q;
  assign swap_out        = swap_q;
  assign front_valid_out = front_valid_q;
  assign col_err_out     = err_q;
  assign sx_out          = sx_q2;
  assign sy_out          = sy_q2;
  assign de_out          = de_q2;
  assign r_out           = rgb_q[23:16];
  assign g_out           = rgb_q[15:8];
  assign b_out           = rgb_q[7:0];

endmodule

// File: tb/tb_column_painter.sv
// Randomized bench for column_painter: a frame-level model of the two banks predicts every
// output cycle by cycle, and hand-computed probes pin the model.
module tb_column_painter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [9:0]  wr_col = '0;
  logic        wr_vert = 1'b0;
  logic [31:0] wr_height = '0;
  logic        wr_last = 1'b0;
  logic [9:0]  sx = '0, sy = '0;
  logic        de = 1'b0;
  logic [9:0]  sx_o, sy_o;
  logic        de_o;
  logic [7:0]  r_o, g_o, b_o;
  logic        swap_o, fv_o, err_o;

  int total = 0;
  int bad = 0;
  int swaps = 0;

  column_painter dut (
    .clk_in(clk), .rst_in(rst_n), .frame_in(frame),
    .wr_valid_in(wr_valid), .wr_ready_out(wr_ready), .wr_col_in(wr_col),
    .wr_is_vert_in(wr_vert), .wr_height_in(wr_height), .wr_last_in(wr_last),
    .sx_in(sx), .sy_in(sy), .de_in(de),
    .sx_out(sx_o), .sy_out(sy_o), .de_out(de_o),
    .r_out(r_o), .g_out(g_o), .b_out(b_o),
    .swap_out(swap_o), .front_valid_out(fv_o), .col_err_out(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_half [2][640];
  bit   m_vert [2][640];
  bit   m_front, m_fv, m_full, m_swap, m_err, m_ready;
  logic [9:0]  pend_sx, pend_sy, exp_sx, exp_sy;
  logic        pend_de, exp_de;
  logic [23:0] pend_rgb, exp_rgb;

  function automatic int sat_half(input logic [31:0] h);
    int s;
    s = int'($signed(h)) >>> 17;
    if (s < 0) return 0;
    if (s > 240) return 240;
    return s;
  endfunction

  function automatic logic [23:0] colour(input bit fv, input int half, input bit vert,
                                         input int row, input bit en);
    int dy;
    if (!en) return 24'h000000;
    dy = row - 240;
    if (fv && dy > -half && dy < half) return vert ? 24'hff00ff : 24'hcc0000;
    return 24'h113377;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit acc;
    int col;
    if (!rst_n) begin
      m_front = 0; m_fv = 0; m_full = 0; m_swap = 0; m_err = 0; m_ready = 0;
      pend_sx = '0; pend_sy = '0; pend_de = 0; pend_rgb = '0;
      exp_sx = '0; exp_sy = '0; exp_de = 0; exp_rgb = '0;
    end else begin
      acc = wr_valid && m_ready;
      exp_sx = pend_sx; exp_sy = pend_sy; exp_de = pend_de; exp_rgb = pend_rgb;
      col = int'(sx);
      pend_sx = sx; pend_sy = sy; pend_de = de;
      if (col < 640)
        pend_rgb = colour(m_fv, m_half[m_front][col], m_vert[m_front][col], int'(sy), de);
      else
        pend_rgb = colour(m_fv, 0, 0, int'(sy), de);
      if (acc) begin
        if (int'(wr_col) < 640) begin
          m_half[!m_front][wr_col] = sat_half(wr_height);
          m_vert[!m_front][wr_col] = wr_vert;
        end else begin
          m_err = 1;
        end
      end
      m_swap = 0;
      if (m_full && frame) begin
        m_front = !m_front; m_fv = 1; m_full = 0; m_swap = 1;
      end else if (!m_full && acc && wr_last) begin
        m_full = 1;
      end
      m_ready = !m_full;
    end
  end

  // One compare process, every cycle.
  always @(negedge clk) begin
    chk("pos", {11'd0, de_o, sx_o, sy_o}, {11'd0, exp_de, exp_sx, exp_sy});
    chk("rgb", {8'd0, r_o, g_o, b_o}, {8'd0, exp_rgb});
    chk("status", {28'd0, wr_ready, swap_o, fv_o, err_o}, {28'd0, m_ready, m_swap, m_fv, m_err});
    if (swap_o) swaps++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input int col, input bit vert, input logic [31:0] h, input bit last,
                    input bit frm);
    int n = 0;
    wr_valid = 1; wr_col = col[9:0]; wr_vert = vert; wr_height = h; wr_last = last;
    frame = frm;
    while (!wr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) begin
      total++; bad++;
      $display("FAIL wr_timeout: ready stuck low, expected high for col %0d", col);
    end
    @(negedge clk);
    wr_valid = 0; wr_last = 0; frame = 0;
  endtask

  task automatic pulse_frame();
    frame = 1;
    @(negedge clk);
    frame = 0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_height();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return (32'($urandom_range(0, 260)) << 17) | ($urandom & 32'h1FFFF);
  endfunction

  task automatic scan_cols(input int n);
    for (int k = 0; k < n; k++) begin
      int c;
      c = $urandom_range(0, 639);
      for (int y = 0; y < 482; y++) begin
        sx = c[9:0]; sy = y[9:0]; de = (y < 480);
        @(negedge clk);
      end
      sx = 10'd700; sy = 10'd10; de = 0;
      @(negedge clk);
    end
    de = 0; sx = '0; sy = '0;
  endtask

  task automatic probe(input int c, input int y, input bit en, input logic [23:0] want,
                       input string name);
    sx = c[9:0]; sy = y[9:0]; de = en;
    @(negedge clk);
    de = 0; sx = '0; sy = '0;
    @(negedge clk);
    chk(name, {8'd0, r_o, g_o, b_o}, {8'd0, want});
    chk({name, "_pos"}, {11'd0, de_o, sx_o, sy_o}, {11'd0, en, c[9:0], y[9:0]});
  endtask

  task automatic fill_random(input int from, input int to, input bit last);
    for (int c = from; c <= to; c++) wr(c, 1'($urandom), rand_height(), last && c == to, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_status", {29'd0, swap_o, fv_o, err_o}, 32'd0);
    chk("rst_rgb", {8'd0, r_o, g_o, b_o}, 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, wr_ready}, 32'd1);

    // No frame written yet: background and blanking only.
    scan_cols(3);
    probe(10, 100, 1, 24'h113377, "empty_bg");
    probe(10, 480, 0, 24'h000000, "empty_blank");
    chk("no_swap_yet", swaps, 0);

    // Uniform frame, half = 50, vertical.
    for (int c = 0; c < 640; c++) wr(c, 1, 32'h0064_0000, c == 639, 0);
    pulse_frame();
    chk("swap_once", swaps, 1);
    chk("front_valid", {31'd0, fv_o}, 32'd1);
    probe(100, 191, 1, 24'hff00ff, "h100_r191");
    probe(100, 190, 1, 24'h113377, "h100_r190");
    probe(100, 289, 1, 24'hff00ff, "h100_r289");
    probe(100, 290, 1, 24'h113377, "h100_r290");
    scan_cols(3);

    // Saturation patterns; incomplete frame first.
    for (int c = 0; c < 320; c++) begin
      unique case (c % 4)
        0: wr(c, 1, 32'h7FFF_0000, 0, 0);
        1: wr(c, 1, 32'hFFF0_0000, 0, 0);
        2: wr(c, 0, 32'h0064_0000, 0, 0);
        default: wr(c, 1'($urandom), rand_height(), 0, 0);
      endcase
    end
    pulse_frame();
    chk("incomplete_no_swap", swaps, 1);
    chk("incomplete_ready", {31'd0, wr_ready}, 32'd1);
    probe(100, 240, 1, 24'hff00ff, "old_frame_repeat");
    for (int c = 320; c < 640; c++) begin
      unique case (c % 4)
        0: wr(c, 1, 32'h7FFF_0000, c == 639, 0);
        1: wr(c, 1, 32'hFFF0_0000, c == 639, 0);
        2: wr(c, 0, 32'h0064_0000, c == 639, 0);
        default: wr(c, 1'($urandom), rand_height(), c == 639, 0);
      endcase
    end
    wr_valid = 1; wr_col = 10'd5; wr_height = 32'h0001_0000; wr_vert = 0;
    repeat (5) @(negedge clk);
    chk("done_ready_low", {31'd0, wr_ready}, 32'd0);
    wr_valid = 0;
    pulse_frame();
    chk("swap_twice", swaps, 2);
    probe(0, 0, 1, 24'h113377, "sat_row0");
    probe(0, 1, 1, 24'hff00ff, "sat_row1");
    probe(0, 479, 1, 24'hff00ff, "sat_row479");
    probe(5, 240, 1, 24'h113377, "neg_bg");
    probe(2, 240, 1, 24'hcc0000, "horiz_wall");
    scan_cols(4);

    // Random frame written while scanning; last write coincides with frame_in.
    fork
      begin
        fill_random(0, 638, 0);
        wr(639, 1'($urandom), rand_height(), 1, 1);
      end
      scan_cols(2);
    join
    repeat (3) @(negedge clk);
    chk("same_edge_no_swap", swaps, 2);
    chk("same_edge_done", {31'd0, wr_ready}, 32'd0);
    pulse_frame();
    chk("swap_third", swaps, 3);
    scan_cols(3);

    // Out-of-range column, then another random frame.
    wr(700, 1, 32'h7FFF_0000, 0, 0);
    chk("col_err_set", {31'd0, err_o}, 32'd1);
    fill_random(0, 639, 1);
    pulse_frame();
    chk("col_err_sticky", {31'd0, err_o}, 32'd1);
    chk("swap_fourth", swaps, 4);

    // Asynchronous reset in the middle of a scan.
    fork
      scan_cols(2);
      begin
        repeat (300) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_rgb", {8'd0, r_o, g_o, b_o}, 32'd0);
        chk("arst_pos", {11'd0, de_o, sx_o, sy_o}, 32'd0);
        chk("arst_status", {28'd0, wr_ready, swap_o, fv_o, err_o}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1;
      end
    join
    chk("post_rst_fv", {31'd0, fv_o}, 32'd0);
    chk("post_rst_ready", {31'd0, wr_ready}, 32'd1);
    probe(50, 240, 1, 24'h113377, "post_rst_bg");
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
